// File: rtl/pending_req_encoder.sv
// Sticky request capture feeding a lowest-index-first binary encoder.
// Issues one index per cycle over a valid/ready handshake.
module pending_req_encoder #(
    parameter  int N = 32,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] req,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         dropped
);

    logic         slot_free;
    logic         pop;
    logic [N-1:0] lowest_bit;
    logic [N-1:0] pop_mask;
    logic [N-1:0] cap;
    logic [W-1:0] pop_idx;

    // Two's-complement trick isolates the lowest set bit of pending.
    assign lowest_bit = pending & (~pending + N'(1));
    assign slot_free  = ~out_valid | out_ready;
    assign pop        = enable & slot_free & (|pending);
    assign pop_mask   = pop ? lowest_bit : '0;
    assign cap        = enable ? req : '0;

    // NOTE: default assignment before the loop keeps this combinational (no latch).
    always_comb begin
        pop_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pop_mask[i]) pop_idx |= W'(i);
        end
    end

    // NOTE: non-blocking assignments so every register sees pre-edge state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            dropped   <= 1'b0;
        end else begin
            pending <= (pending & ~pop_mask) | cap;
            dropped <= |(cap & pending & ~pop_mask);
            if (pop) begin
                out_valid <= 1'b1;
                out_idx   <= pop_idx;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // A stalled output must hold its index until accepted.
    a_stall_stable: assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_idx)));

    a_pop_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(pop_mask));

endmodule

// File: tb/tb_pending_req_encoder.sv
// Directed-vector bench for pending_req_encoder: one task per scenario.
module tb_pending_req_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] req;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic        out_ready;
    logic [31:0] pending;
    logic        dropped;

    int tests = 0;
    int fails = 0;

    pending_req_encoder #(.N(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending   (pending),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; out_ready = 1'b1; req = '1;
        #2;
        repeat (3) begin
            tick();
            tests++;
            if ({pending, out_valid, out_idx, dropped} !== 39'd0) begin
                fails++;
                $display("FAIL reset_hold: pending=%h valid=%b idx=%0d dropped=%b, want all 0",
                         pending, out_valid, out_idx, dropped);
            end
        end
        reset = 1'b1;
        tick();
        tests++;
        if (pending !== 32'hFFFF_FFFF || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_capture: pending=%h valid=%b, want ffffffff/0", pending, out_valid);
        end
        req = '0;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd0 || pending !== 32'hFFFF_FFFE) begin
            fails++;
            $display("FAIL reset_first_valid: valid=%b idx=%0d pending=%h, want 1/0/fffffffe",
                     out_valid, out_idx, pending);
        end
        for (int k = 1; k < 32; k++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_idx !== 5'(k)) begin
                fails++;
                $display("FAIL reset_drain_%0d: valid=%b idx=%0d, want 1/%0d", k, out_valid, out_idx, k);
            end
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || pending !== 32'd0) begin
            fails++;
            $display("FAIL reset_drain_end: valid=%b pending=%h, want 0/0", out_valid, pending);
        end
    endtask

    task automatic test_burst();
        logic [4:0] exp_idx [4];
        exp_idx = '{5'd0, 5'd5, 5'd10, 5'd15};
        enable = 1'b1; out_ready = 1'b1; req = 32'h0000_8421;
        tick();
        req = '0;
        tests++;
        if (pending !== 32'h0000_8421 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL burst_capture: pending=%h valid=%b, want 00008421/0", pending, out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[k]) begin
                fails++;
                $display("FAIL burst_issue_%0d: valid=%b idx=%0d, want 1/%0d", k, out_valid, out_idx, exp_idx[k]);
            end
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || pending !== 32'd0) begin
            fails++;
            $display("FAIL burst_empty: valid=%b pending=%h, want 0/0", out_valid, pending);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; req = 32'h8;
        tick();
        req = 32'h2;
        tick();
        req = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_idx !== 5'd3 || pending !== 32'h2) begin
                fails++;
                $display("FAIL stall_hold_%0d: valid=%b idx=%0d pending=%h, want 1/3/2",
                         k, out_valid, out_idx, pending);
            end
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd1 || pending !== 32'd0) begin
            fails++;
            $display("FAIL stall_release: valid=%b idx=%0d pending=%h, want 1/1/0", out_valid, out_idx, pending);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_empty: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_dropped();
        out_ready = 1'b0; req = 32'h1;
        tick();
        req = 32'h80;
        tick();
        req = 32'h80;
        tick();
        tests++;
        if (dropped !== 1'b1 || pending !== 32'h80) begin
            fails++;
            $display("FAIL drop_pulse: dropped=%b pending=%h, want 1/00000080", dropped, pending);
        end
        req = '0;
        tick();
        tests++;
        if (dropped !== 1'b0) begin
            fails++;
            $display("FAIL drop_single_cycle: dropped=%b, want 0", dropped);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd7 || pending !== 32'd0) begin
            fails++;
            $display("FAIL drop_issue7: valid=%b idx=%0d pending=%h, want 1/7/0", out_valid, out_idx, pending);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_once: valid=%b, want 0 (idx 7 issued once)", out_valid);
        end
        req = 32'h80;
        tick();
        tick();
        req = '0;
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd7 || dropped !== 1'b0 || pending !== 32'h80) begin
            fails++;
            $display("FAIL repop_first: valid=%b idx=%0d dropped=%b pending=%h, want 1/7/0/00000080",
                     out_valid, out_idx, dropped, pending);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd7 || pending !== 32'd0) begin
            fails++;
            $display("FAIL repop_second: valid=%b idx=%0d pending=%h, want 1/7/0", out_valid, out_idx, pending);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL repop_end: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_enable();
        out_ready = 1'b0; req = 32'h4;
        tick();
        req = '0;
        tick();
        enable = 1'b0; req = 32'h10;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd2 || pending !== 32'd0) begin
            fails++;
            $display("FAIL en_hold: valid=%b idx=%0d pending=%h, want 1/2/0", out_valid, out_idx, pending);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || pending !== 32'd0) begin
            fails++;
            $display("FAIL en_accept: valid=%b pending=%h, want 0/0", out_valid, pending);
        end
        req = '0;
        tick();
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0 || pending !== 32'd0) begin
                fails++;
                $display("FAIL en_no_spurious_%0d: valid=%b pending=%h, want 0/0", k, out_valid, pending);
            end
        end
    endtask

    task automatic test_midreset();
        out_ready = 1'b0; req = 32'h1;
        tick();
        req = 32'hFFFF_0000;
        tick();
        req = '0;
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd0 || pending !== 32'hFFFF_0000) begin
            fails++;
            $display("FAIL mid_setup: valid=%b idx=%0d pending=%h, want 1/0/ffff0000", out_valid, out_idx, pending);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({pending, out_valid, out_idx, dropped} !== 39'd0) begin
            fails++;
            $display("FAIL mid_async_clear: pending=%h valid=%b idx=%0d dropped=%b, want all 0",
                     pending, out_valid, out_idx, dropped);
        end
        tick();
        reset = 1'b1; out_ready = 1'b1; req = 32'h8000_0000;
        tick();
        req = '0;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd31) begin
            fails++;
            $display("FAIL mid_idx31: valid=%b idx=%0d, want 1/31", out_valid, out_idx);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || pending !== 32'd0) begin
            fails++;
            $display("FAIL mid_end: valid=%b pending=%h, want 0/0", out_valid, pending);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_dropped();
        test_enable();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
